pong_match_ctrl: RTL

//  Parametrised match controller for the Pong game. Owns the game FSM, both player scores,
//  the mm:ss countdown and the serve delay. Consumes miss events from the ball/paddle engine.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/match_timer.sv | 44 ++++
 rtl/pong_match_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the Pong match controller: FSM state codes, winner codes, BCD digit width.
package pong_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [2:0] {
    NEW_GAME = 3'd0,
    PLAY     = 3'd1,
    NEW_BALL = 3'd2,
    OVER     = 3'd3,
    OVERTIME = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

endpackage

// File: rtl/match_timer.sv
// BCD mm:ss down-counter; reloads to MATCH_MIN:00 on load, holds at 0:00 instead of wrapping.
module match_timer
  import pong_pkg::*;
#(
  parameter int unsigned MATCH_MIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [BCD_W-1:0] min,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             zero_c
);

  assign zero_c = (min == '0) && (sec_tens == '0) && (sec_ones == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min      <= BCD_W'(MATCH_MIN);
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (load) begin
      min      <= BCD_W'(MATCH_MIN);
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (en && !zero_c) begin
      // Borrow chain: ones -> tens -> minutes.
      if (sec_ones != '0) begin
        sec_ones <= sec_ones - BCD_W'(1);
      end else begin
        sec_ones <= BCD_W'(9);
        if (sec_tens != '0) begin
          sec_tens <= sec_tens - BCD_W'(1);
        end else begin
          sec_tens <= BCD_W'(5);
          min      <= min - BCD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: game FSM, scores, serve delay and mm:ss countdown.
// Define PONG_SUDDEN_DEATH_EN to play a sudden-death OVERTIME after a tied timeout.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned MATCH_MIN   = 3,
  parameter int unsigned NEWBALL_CYC = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick_1hz,
  input  logic               miss1,
  input  logic               miss2,
  output logic               stop,
  output logic               serve,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [BCD_W-1:0]   min,
  output logic [BCD_W-1:0]   sec_tens,
  output logic [BCD_W-1:0]   sec_ones,
  output logic [2:0]         state,
  output logic [1:0]         winner,
  output logic               game_over
);

  localparam int unsigned DLY_W = $clog2(NEWBALL_CYC + 1);

  state_e             st;
  winner_e            win;
  logic               start_q;
  logic               in_ot;
  logic [DLY_W-1:0]   dly;
  logic               start_rise;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;
  logic [SCORE_W-1:0] s1_inc;
  logic [SCORE_W-1:0] s2_inc;

  assign state      = st;
  assign winner     = win;
  assign start_rise = start & ~start_q;
  assign s1_inc     = score1 + SCORE_W'(1);
  assign s2_inc     = score2 + SCORE_W'(1);
  assign tmr_en     = (st == PLAY) & tick_1hz;
  assign tmr_load   = (st == NEW_GAME) | ((st == OVER) & start_rise);

  match_timer #(
    .MATCH_MIN(MATCH_MIN)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .min     (min),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .zero_c  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= NEW_GAME;
      win       <= W_NONE;
      score1    <= '0;
      score2    <= '0;
      stop      <= 1'b1;
      serve     <= 1'b0;
      game_over <= 1'b0;
      start_q   <= 1'b0;
      in_ot     <= 1'b0;
      dly       <= '0;
    end else begin
      start_q <= start;
      serve   <= 1'b0;
      case (st)
        NEW_GAME: begin
          score1 <= '0;
          score2 <= '0;
          win    <= W_NONE;
          in_ot  <= 1'b0;
          if (start_rise) begin
            st    <= PLAY;
            stop  <= 1'b0;
            serve <= 1'b1;
          end
        end
        PLAY, OVERTIME: begin
          // Misses take priority over a timeout in the same cycle; a double miss is a let.
          if (miss1 && miss2) begin
            st   <= NEW_BALL;
            stop <= 1'b1;
            dly  <= DLY_W'(NEWBALL_CYC);
          end else if (miss1) begin
            score2 <= s2_inc;
            stop   <= 1'b1;
            if (s2_inc == SCORE_W'(WIN_SCORE) || st == OVERTIME) begin
              st        <= OVER;
              win       <= W_P2;
              game_over <= 1'b1;
            end else begin
              st  <= NEW_BALL;
              dly <= DLY_W'(NEWBALL_CYC);
            end
          end else if (miss2) begin
            score1 <= s1_inc;
            stop   <= 1'b1;
            if (s1_inc == SCORE_W'(WIN_SCORE) || st == OVERTIME) begin
              st        <= OVER;
              win       <= W_P1;
              game_over <= 1'b1;
            end else begin
              st  <= NEW_BALL;
              dly <= DLY_W'(NEWBALL_CYC);
            end
          end else if (st == PLAY && tmr_zero) begin
            if (score1 > score2) begin
              st        <= OVER;
              win       <= W_P1;
              stop      <= 1'b1;
              game_over <= 1'b1;
            end else if (score2 > score1) begin
              st        <= OVER;
              win       <= W_P2;
              stop      <= 1'b1;
              game_over <= 1'b1;
            end else begin
`ifdef PONG_SUDDEN_DEATH_EN
              st    <= OVERTIME;
              in_ot <= 1'b1;
`else
              st        <= OVER;
              win       <= W_DRAW;
              stop      <= 1'b1;
              game_over <= 1'b1;
`endif
            end
          end
        end
        NEW_BALL: begin
          // Relaunch waits for the delay to expire and the start switch to be up.
          if (dly != '0) begin
            dly <= dly - DLY_W'(1);
          end else if (start) begin
            st    <= in_ot ? OVERTIME : PLAY;
            stop  <= 1'b0;
            serve <= 1'b1;
          end
        end
        OVER: begin
          if (start_rise) begin
            st        <= NEW_GAME;
            win       <= W_NONE;
            game_over <= 1'b0;
            score1    <= '0;
            score2    <= '0;
          end
        end
        default: begin
          st   <= NEW_GAME;
          stop <= 1'b1;
        end
      endcase
    end
  end

endmodule
